// File: rtl/dds_voice_envelope_ctrl.sv
// Per-voice note controller for one DDS oscillator: valid/ready event intake,
// tick-driven ADSR volume envelope, frequency word latch and phase-restart pulse.
module dds_voice_envelope_ctrl #(
  parameter int PHASE_WIDTH = 32,
  parameter int RATE_DIV    = 48000
) (
  input  logic                   clk,
  input  logic                   rst_active_low,
  input  logic                   evt_valid,
  output logic                   evt_ready,
  input  logic                   evt_type,
  input  logic [PHASE_WIDTH-1:0] evt_freq_word,
  input  logic [5:0]             evt_peak_vol,
  input  logic [5:0]             evt_sustain_vol,
  input  logic [5:0]             attack_rate,
  input  logic [5:0]             decay_rate,
  input  logic [5:0]             release_rate,
  output logic [PHASE_WIDTH-1:0] freq_word,
  output logic [5:0]             vol,
  output logic                   dds_rst_active_high,
  output logic                   busy,
  output logic [2:0]             env_state
);

  localparam int CW = (RATE_DIV > 2) ? $clog2(RATE_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic                   evt_ready_q;
  logic                   dds_rst_q;
  logic [PHASE_WIDTH-1:0] freq_q;
  logic [5:0]             vol_q;
  logic [5:0]             peak_q;
  logic [5:0]             sus_q;

  logic                   tick;
  logic                   accept;
  logic [6:0]             atk_sum_d;
  logic [5:0]             atk_vol_d;
  logic [6:0]             dec_step_d;
  logic [5:0]             dec_vol_d;
  logic [6:0]             rel_step_d;
  logic [5:0]             rel_vol_d;

  // A zero rate means "jump in one tick", i.e. the full-scale step.
  function automatic logic [6:0] rate_step(input logic [5:0] r);
    return (r == 6'd0) ? 7'd63 : {1'b0, r};
  endfunction

  assign tick   = (cnt_q == CW'(RATE_DIV - 1));
  assign accept = evt_valid && evt_ready_q;

  // Saturating 7-bit candidates for each envelope phase.
  always_comb begin
    atk_sum_d  = {1'b0, vol_q} + rate_step(attack_rate);
    atk_vol_d  = peak_q;
    dec_step_d = rate_step(decay_rate);
    dec_vol_d  = sus_q;
    rel_step_d = rate_step(release_rate);
    rel_vol_d  = 6'd0;
    if (atk_sum_d < {1'b0, peak_q}) atk_vol_d = atk_sum_d[5:0];
    if ({1'b0, vol_q} >= ({1'b0, sus_q} + dec_step_d)) dec_vol_d = vol_q - dec_step_d[5:0];
    if ({1'b0, vol_q} >= rel_step_d) rel_vol_d = vol_q - rel_step_d[5:0];
  end

  always_ff @(posedge clk or negedge rst_active_low) begin
    if (!rst_active_low) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      evt_ready_q <= 1'b0;
      dds_rst_q   <= 1'b1;
      freq_q      <= '0;
      vol_q       <= 6'd0;
      peak_q      <= 6'd0;
      sus_q       <= 6'd0;
    end else begin
      cnt_q       <= tick ? '0 : cnt_q + CW'(1);
      evt_ready_q <= !accept;
      dds_rst_q   <= accept && evt_type && (state_q == IDLE);
      if (accept) begin
        // An accepted event pre-empts any envelope step due this cycle.
        if (evt_type) begin
          freq_q  <= evt_freq_word;
          peak_q  <= evt_peak_vol;
          sus_q   <= (evt_sustain_vol < evt_peak_vol) ? evt_sustain_vol : evt_peak_vol;
          state_q <= ATTACK;
        end else if (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN) begin
          state_q <= RELEASE;
        end
      end else if (tick) begin
        case (state_q)
          ATTACK: begin
            vol_q <= atk_vol_d;
            if (atk_vol_d == peak_q) state_q <= DECAY;
          end
          DECAY: begin
            vol_q <= dec_vol_d;
            if (dec_vol_d == sus_q) state_q <= SUSTAIN;
          end
          RELEASE: begin
            vol_q <= rel_vol_d;
            if (rel_vol_d == 6'd0) state_q <= IDLE;
          end
          IDLE:    vol_q <= 6'd0;
          default: ;
        endcase
      end
    end
  end

  assign evt_ready           = evt_ready_q;
  assign freq_word           = freq_q;
  assign vol                 = vol_q;
  assign dds_rst_active_high = dds_rst_q;
  assign busy                = (state_q != IDLE);
  assign env_state           = state_q;

endmodule

// File: tb/tb_dds_voice_envelope_ctrl.sv
// Self-checking bench: directed envelope scenarios plus randomized events,
// all compared every cycle against a spec-level behavioural model.
module tb_dds_voice_envelope_ctrl;
  localparam int PW = 32;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst_active_low;
  logic          evt_valid;
  logic          evt_ready;
  logic          evt_type;
  logic [PW-1:0] evt_freq_word;
  logic [5:0]    evt_peak_vol;
  logic [5:0]    evt_sustain_vol;
  logic [5:0]    attack_rate;
  logic [5:0]    decay_rate;
  logic [5:0]    release_rate;
  logic [PW-1:0] freq_word;
  logic [5:0]    vol;
  logic          dds_rst_active_high;
  logic          busy;
  logic [2:0]    env_state;

  always #5 clk = ~clk;

  dds_voice_envelope_ctrl #(.PHASE_WIDTH(PW), .RATE_DIV(RD)) dut (
    .clk                 (clk),
    .rst_active_low      (rst_active_low),
    .evt_valid           (evt_valid),
    .evt_ready           (evt_ready),
    .evt_type            (evt_type),
    .evt_freq_word       (evt_freq_word),
    .evt_peak_vol        (evt_peak_vol),
    .evt_sustain_vol     (evt_sustain_vol),
    .attack_rate         (attack_rate),
    .decay_rate          (decay_rate),
    .release_rate        (release_rate),
    .freq_word           (freq_word),
    .vol                 (vol),
    .dds_rst_active_high (dds_rst_active_high),
    .busy                (busy),
    .env_state           (env_state)
  );

  // Behavioural model: states 0..4 = idle, attack, decay, sustain, release.
  int            m_state, m_vol, m_peak, m_sus, m_cnt;
  logic [PW-1:0] m_freq;
  bit            m_ready, m_dds;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int step_of(input logic [5:0] r);
    return (r == 6'd0) ? 63 : int'(r);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_vol = 0; m_peak = 0; m_sus = 0; m_cnt = 0;
    m_freq = '0; m_ready = 0; m_dds = 1;
  endtask

  task automatic model_edge();
    bit acc;
    bit tk;
    acc   = evt_valid && m_ready;
    tk    = (m_cnt == RD - 1);
    m_cnt = tk ? 0 : m_cnt + 1;
    m_dds = acc && evt_type && (m_state == 0);
    m_ready = !acc;
    if (acc) begin
      if (evt_type) begin
        m_freq  = evt_freq_word;
        m_peak  = int'(evt_peak_vol);
        m_sus   = imin(int'(evt_sustain_vol), int'(evt_peak_vol));
        m_state = 1;
      end else if (m_state >= 1 && m_state <= 3) begin
        m_state = 4;
      end
    end else if (tk) begin
      case (m_state)
        1: begin
          m_vol = imin(m_vol + step_of(attack_rate), m_peak);
          if (m_vol == m_peak) m_state = 2;
        end
        2: begin
          m_vol = imax(m_vol - step_of(decay_rate), m_sus);
          if (m_vol == m_sus) m_state = 3;
        end
        4: begin
          m_vol = imax(m_vol - step_of(release_rate), 0);
          if (m_vol == 0) m_state = 0;
        end
        default: ;
      endcase
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("vol", vol, m_vol);
      check("env_state", env_state, m_state);
      check("busy", busy, (m_state != 0));
      check("evt_ready", evt_ready, m_ready);
      check("dds_rst", dds_rst_active_high, m_dds);
      check("freq_word", freq_word, m_freq);
    end
  end

  task automatic cyc();
    @(posedge clk);
    if (rst_active_low) model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic align(input int k);
    for (int i = 0; i < RD && m_cnt != k; i++) cyc();
  endtask

  task automatic send(input bit typ, input logic [PW-1:0] f, input logic [5:0] pk, input logic [5:0] su);
    bit done;
    done = 0;
    evt_type = typ; evt_freq_word = f; evt_peak_vol = pk; evt_sustain_vol = su;
    evt_valid = 1'b1;
    for (int i = 0; i < 4 && !done; i++) begin
      done = evt_ready;
      cyc();
    end
    evt_valid = 1'b0;
    check("send_accepted", done, 1);
  endtask

  task automatic wait_vol_change(input string nm, input int exp, input int limit);
    int old;
    int n;
    old = int'(vol);
    n = 0;
    while (int'(vol) == old && n < limit) begin
      cyc();
      n++;
    end
    check(nm, vol, exp);
  endtask

  task automatic wait_state(input string nm, input int st, input int limit);
    int n;
    n = 0;
    while (int'(env_state) != st && n < limit) begin
      cyc();
      n++;
    end
    check(nm, env_state, st);
  endtask

  function automatic logic [5:0] rnd_rate();
    return ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom_range(1, 16));
  endfunction

  initial begin
    int seq [8] = '{10, 20, 30, 40, 35, 30, 25, 20};
    int acc_cnt;
    int n;
    bit prev_acc;
    bit r;

    rst_active_low = 1'b0;
    evt_valid = 1'b0; evt_type = 1'b0; evt_freq_word = '0;
    evt_peak_vol = 6'd0; evt_sustain_vol = 6'd0;
    attack_rate = 6'd10; decay_rate = 6'd5; release_rate = 6'd7;
    model_reset();
    chk_en = 1;
    cyc(); cyc();
    check("rst_ready", evt_ready, 0);
    check("rst_dds", dds_rst_active_high, 1);
    check("rst_vol", vol, 0);
    check("rst_state", env_state, 0);
    check("rst_freq", freq_word, 0);
    check("rst_busy", busy, 0);
    rst_active_low = 1'b1;
    cyc();
    check("rel_ready", evt_ready, 1);
    check("rel_dds", dds_rst_active_high, 0);

    // Basic envelope
    align(0);
    send(1, 32'h0100_0000, 6'd40, 6'd20);
    check("pulse_hi", dds_rst_active_high, 1);
    check("basic_freq", freq_word, 32'h0100_0000);
    check("basic_attack", env_state, 1);
    cyc();
    check("pulse_lo", dds_rst_active_high, 0);
    for (int i = 0; i < 8; i++) wait_vol_change($sformatf("basic_step%0d", i), seq[i], 3 * RD);
    for (int i = 0; i < 3 * RD; i++) cyc();
    check("basic_hold_vol", vol, 20);
    check("basic_sustain", env_state, 3);

    // Release
    align(0);
    send(0, '0, 6'd0, 6'd0);
    check("rel_state", env_state, 4);
    wait_vol_change("rel_13", 13, 3 * RD);
    wait_vol_change("rel_6", 6, 3 * RD);
    wait_vol_change("rel_0", 0, 3 * RD);
    check("rel_idle", env_state, 0);
    check("rel_busy", busy, 0);
    check("rel_freq_held", freq_word, 32'h0100_0000);

    // Retrigger and clamp
    align(0);
    send(1, 32'h0200_0000, 6'd40, 6'd20);
    wait_state("rt_sustain", 3, 60);
    align(0);
    send(0, '0, 6'd0, 6'd0);
    wait_vol_change("rt_rel13", 13, 3 * RD);
    attack_rate = 6'd0;
    send(1, 32'h0300_0000, 6'd63, 6'd63);
    check("rt_no_pulse", dds_rst_active_high, 0);
    check("rt_attack", env_state, 1);
    check("rt_vol_kept", vol, 13);
    wait_vol_change("rt_vol63", 63, 3 * RD);
    check("rt_decay", env_state, 2);
    wait_state("rt_sustain63", 3, RD + 2);
    check("rt_sus_vol", vol, 63);

    // Handshake: valid held for 6 cycles
    acc_cnt = 0;
    prev_acc = 0;
    evt_freq_word = 32'h0400_0000; evt_peak_vol = 6'd50; evt_sustain_vol = 6'd25;
    for (int i = 0; i < 6; i++) begin
      evt_valid = 1'b1;
      evt_type = ((i / 2) % 2) == 1;
      r = evt_ready;
      if (prev_acc) check("hs_ready_low", r, 0);
      if (r) acc_cnt++;
      prev_acc = r;
      cyc();
    end
    evt_valid = 1'b0;
    check("hs_accepts", acc_cnt, 3);
    wait_state("hs_to_idle", 0, 100);

    // Collision: note-off accepted in a tick cycle during attack
    attack_rate = 6'd10;
    align(0);
    send(1, 32'h0500_0000, 6'd60, 6'd30);
    wait_vol_change("col_10", 10, 3 * RD);
    wait_vol_change("col_20", 20, 3 * RD);
    align(RD - 1);
    send(0, '0, 6'd0, 6'd0);
    check("col_vol", vol, 20);
    check("col_release", env_state, 4);
    n = 0;
    while (vol == 6'd20 && n < 20) begin
      cyc();
      n++;
    end
    check("col_delay", n, RD);
    check("col_first_step", vol, 13);
    wait_state("col_idle", 0, 40);

    // Async reset mid-decay
    decay_rate = 6'd1;
    align(0);
    send(1, 32'h0600_0000, 6'd40, 6'd10);
    wait_state("ar_decay", 2, 30);
    cyc();
    rst_active_low = 1'b0;
    model_reset();
    #1;
    check("ar_vol", vol, 0);
    check("ar_freq", freq_word, 0);
    check("ar_ready", evt_ready, 0);
    check("ar_dds", dds_rst_active_high, 1);
    check("ar_state", env_state, 0);
    cyc(); cyc();
    rst_active_low = 1'b1;
    cyc();
    check("ar_rel_ready", evt_ready, 1);
    check("ar_rel_dds", dds_rst_active_high, 0);

    // Peak = 0: attack completes on first tick, decay on the next
    attack_rate = 6'd3; decay_rate = 6'd2;
    align(0);
    send(1, 32'h0700_0000, 6'd0, 6'd5);
    wait_state("p0_decay", 2, 2 * RD);
    check("p0_vol_a", vol, 0);
    wait_state("p0_sustain", 3, 2 * RD);
    check("p0_vol_s", vol, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      evt_valid       = ($urandom_range(0, 2) == 0);
      evt_type        = ($urandom_range(0, 1) == 1);
      evt_freq_word   = $urandom;
      evt_peak_vol    = 6'($urandom_range(0, 63));
      evt_sustain_vol = 6'($urandom_range(0, 63));
      attack_rate     = rnd_rate();
      decay_rate      = rnd_rate();
      release_rate    = rnd_rate();
      if ($urandom_range(0, 799) == 0) begin
        rst_active_low = 1'b0;
        model_reset();
        cyc();
        rst_active_low = 1'b1;
      end
      cyc();
    end
    evt_valid = 1'b0;
    cyc();

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
